// File: rtl/except_arbiter.sv
// except_arbiter
// ---------------------------------------------------------------------------
// MEM-stage exception resolver sitting just upstream of the CP0 register file.
// It gathers the exception flags of the instruction in MEM and the pending
// interrupt condition, then picks one exception code per cycle for CP0 to
// commit. CP0 writes still in WB are forwarded so the decision uses the values
// CP0 is about to hold. On an accepted exception it raises a registered
// pipeline flush for FLUSH_CYCLES cycles and publishes the redirect PC. The
// redirect PC is EXC_VECTOR, or the forwarded EPC for eret.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_valid_i, stall_i    MEM holds a real instruction / MEM is stalled
//   syscall_i, eret_i, inst_invalid_i, trap_i, ov_i
//                            per-instruction exception flags
//   current_inst_addr_i      PC of the MEM instruction
//   is_in_delayslot_i        MEM instruction sits in a delay slot
//   cp0_status_i/cause_i/epc_i   architectural CP0 values
//   wb_cp0_we_i/waddr_i/data_i   in-flight CP0 write from WB
//   excepttype_o             selected exception code (combinational)
//   current_inst_addr_o, is_in_delayslot_o   passthroughs to CP0
//   cp0_epc_o                forwarded EPC
//   flush_o, new_pc_o        registered flush and redirect target
//   int_pending_o            interrupt requested but not yet taken
// ---------------------------------------------------------------------------
module except_arbiter #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic        syscall_i,
    input  logic        eret_i,
    input  logic        inst_invalid_i,
    input  logic        trap_i,
    input  logic        ov_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] cp0_epc_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        int_pending_o
);

    // The flush counter is two bits wide, so only 1..4 flush cycles fit.
    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
            $error("except_arbiter: FLUSH_CYCLES must be in 1..4");
        end
    endgenerate

    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [31:0] CODE_INT     = 32'h0000_0001;
    localparam logic [31:0] CODE_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] CODE_INVALID = 32'h0000_000a;
    localparam logic [31:0] CODE_TRAP    = 32'h0000_000d;
    localparam logic [31:0] CODE_OV      = 32'h0000_000c;
    localparam logic [31:0] CODE_ERET    = 32'h0000_000e;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        int_pending_q, int_pending_d;

    logic [31:0] status_fwd;
    logic [31:0] cause_fwd;
    logic [31:0] epc_fwd;
    logic        int_cond;
    logic        take;

    // Software may only write the IP[1:0] soft-interrupt bits and the IV/WP
    // bits (23:22) of Cause, so a WB write to Cause only replaces those bits.
    always_comb begin
        status_fwd = cp0_status_i;
        cause_fwd  = cp0_cause_i;
        epc_fwd    = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_STATUS) begin
            status_fwd = wb_cp0_data_i;
        end
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_CAUSE) begin
            cause_fwd[9:8] = wb_cp0_data_i[9:8];
            cause_fwd[22]  = wb_cp0_data_i[22];
            cause_fwd[23]  = wb_cp0_data_i[23];
        end
        if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_EPC) begin
            epc_fwd = wb_cp0_data_i;
        end
    end

    // Interrupts need IE set, EXL clear and at least one unmasked pending line.
    assign int_cond = status_fwd[0] & ~status_fwd[1] &
                      (|(cause_fwd[15:8] & status_fwd[15:8]));

    // Only a real, moving instruction outside a flush may commit an exception.
    assign take = inst_valid_i & ~stall_i & (state_q == RUN) & ~rst;

    always_comb begin
        excepttype_o = 32'h0;
        if (take) begin
            if (int_cond)            excepttype_o = CODE_INT;
            else if (syscall_i)      excepttype_o = CODE_SYSCALL;
            else if (inst_invalid_i) excepttype_o = CODE_INVALID;
            else if (trap_i)         excepttype_o = CODE_TRAP;
            else if (ov_i)           excepttype_o = CODE_OV;
            else if (eret_i)         excepttype_o = CODE_ERET;
            else                     excepttype_o = 32'h0;
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        new_pc_d      = new_pc_q;
        cnt_d         = cnt_q;
        int_pending_d = int_cond & ~(take & int_cond);
        case (state_q)
            RUN: begin
                if (excepttype_o != 32'h0) begin
                    state_d  = FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = (excepttype_o == CODE_ERET) ? epc_fwd : EXC_VECTOR;
                    cnt_d    = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt_q == 2'd0) begin
                    state_d = RUN;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0;
            cnt_q         <= 2'd0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
            cnt_q         <= cnt_d;
            int_pending_q <= int_pending_d;
        end
    end

    assign current_inst_addr_o = current_inst_addr_i;
    assign is_in_delayslot_o   = is_in_delayslot_i;
    assign cp0_epc_o           = epc_fwd;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;
    assign int_pending_o       = int_pending_q;

    // Status and Cause fields that play no part in interrupt qualification.
    logic unused_bits;
    assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2],
                           cause_fwd[31:16], cause_fwd[7:0]};

endmodule

// File: tb/tb_except_arbiter.sv
// tb_except_arbiter
// ---------------------------------------------------------------------------
// Drives two except_arbiter instances from shared inputs: one with
// FLUSH_CYCLES=1 (suffix _a) and one with FLUSH_CYCLES=3 (suffix _b).
// A behavioural model describes each flush as a window of cycle numbers
// and checks every output on every falling edge. Directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_except_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i, stall_i, syscall_i, eret_i, inst_invalid_i, trap_i, ov_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;

    logic [31:0] exc_a, pc_o_a, epc_a, new_pc_a;
    logic        ds_a, flush_a, pend_a;
    logic [31:0] exc_b, pc_o_b, epc_b, new_pc_b;
    logic        ds_b, flush_b, pend_b;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    except_arbiter #(.EXC_VECTOR(32'h0000_0040), .FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .stall_i(stall_i),
        .syscall_i(syscall_i), .eret_i(eret_i), .inst_invalid_i(inst_invalid_i),
        .trap_i(trap_i), .ov_i(ov_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(exc_a), .current_inst_addr_o(pc_o_a), .is_in_delayslot_o(ds_a),
        .cp0_epc_o(epc_a), .flush_o(flush_a), .new_pc_o(new_pc_a), .int_pending_o(pend_a)
    );

    except_arbiter #(.EXC_VECTOR(32'h0000_0040), .FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .stall_i(stall_i),
        .syscall_i(syscall_i), .eret_i(eret_i), .inst_invalid_i(inst_invalid_i),
        .trap_i(trap_i), .ov_i(ov_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(exc_b), .current_inst_addr_o(pc_o_b), .is_in_delayslot_o(ds_b),
        .cp0_epc_o(epc_b), .flush_o(flush_b), .new_pc_o(new_pc_b), .int_pending_o(pend_b)
    );

    // Shared comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A flush is the window of cycles (exception cycle + 1 .. + FLUSH_CYCLES).
    int          cyc = 0;
    int          flush_last [2] = '{0, 0};
    logic [31:0] model_pc   [2] = '{32'h0, 32'h0};
    logic        model_pend [2] = '{1'b0, 1'b0};
    int          fc         [2] = '{1, 3};

    // Highest-priority active cause wins; the list is in priority order.
    function automatic logic [31:0] pickCode(input logic [5:0] active);
        logic [31:0] codes [6] = '{32'h1, 32'h8, 32'ha, 32'hd, 32'hc, 32'he};
        for (int i = 0; i < 6; i++) begin
            if (active[5 - i]) return codes[i];
        end
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            logic [31:0] st, ca, ep, code;
            logic        intc, flushing, tk;
            logic [31:0] got_exc, got_new_pc;
            logic        got_flush, got_pend;
            cyc++;
            st = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
            ca = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13)
                 ? ((cp0_cause_i & ~32'h00C0_0300) | (wb_cp0_data_i & 32'h00C0_0300))
                 : cp0_cause_i;
            ep = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : cp0_epc_i;
            intc = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h0);

            checkOutput("model epc_a", epc_a, ep);
            checkOutput("model epc_b", epc_b, ep);
            checkOutput("model pc passthrough", pc_o_a, current_inst_addr_i);
            checkOutput("model delayslot passthrough", {31'h0, ds_b}, {31'h0, is_in_delayslot_i});

            for (int m = 0; m < 2; m++) begin
                got_exc    = (m == 0) ? exc_a    : exc_b;
                got_flush  = (m == 0) ? flush_a  : flush_b;
                got_new_pc = (m == 0) ? new_pc_a : new_pc_b;
                got_pend   = (m == 0) ? pend_a   : pend_b;
                flushing = (cyc <= flush_last[m]);
                tk = inst_valid_i && !stall_i && !flushing && !rst;
                code = tk ? pickCode({intc, syscall_i, inst_invalid_i, trap_i, ov_i, eret_i}) : 32'h0;

                checkOutput($sformatf("model excepttype[%0d]", m), got_exc, code);
                checkOutput($sformatf("model flush[%0d]", m), {31'h0, got_flush}, {31'h0, flushing});
                checkOutput($sformatf("model new_pc[%0d]", m), got_new_pc, model_pc[m]);
                checkOutput($sformatf("model int_pending[%0d]", m), {31'h0, got_pend}, {31'h0, model_pend[m]});

                if (rst) begin
                    flush_last[m] = cyc;
                    model_pc[m]   = 32'h0;
                    model_pend[m] = 1'b0;
                end else begin
                    model_pend[m] = intc && !tk;
                    if (code != 32'h0) begin
                        flush_last[m] = cyc + fc[m];
                        model_pc[m]   = (code == 32'he) ? ep : 32'h0000_0040;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drives one cycle's instruction flags, then lets combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic st, input logic sc,
                                 input logic er, input logic inv, input logic tr,
                                 input logic o);
        inst_valid_i   = v;
        stall_i        = st;
        syscall_i      = sc;
        eret_i         = er;
        inst_invalid_i = inv;
        trap_i         = tr;
        ov_i           = o;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            nextCycle();
        end
    endtask

    task automatic clearCp0();
        cp0_status_i   = 32'h0;
        cp0_cause_i    = 32'h0;
        cp0_epc_i      = 32'h0;
        wb_cp0_we_i    = 1'b0;
        wb_cp0_waddr_i = 5'd0;
        wb_cp0_data_i  = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        current_inst_addr_i = 32'h0;
        is_in_delayslot_i   = 1'b0;
        clearCp0();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        armed = 1'b1;

        // Reset state; a syscall while in reset is not reported.
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("reset flush_o", {31'h0, flush_a}, 32'h0);
        checkOutput("reset new_pc_o", new_pc_a, 32'h0);
        checkOutput("reset int_pending_o", {31'h0, pend_b}, 32'h0);
        checkOutput("excepttype during rst", exc_a, 32'h0);
        nextCycle();
        rst = 1'b0;
        idleCycles(1);

        // Syscall -> code 8, one-cycle flush to the vector.
        current_inst_addr_i = 32'h1000_0010;
        is_in_delayslot_i   = 1'b1;
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("syscall code", exc_a, 32'h8);
        checkOutput("syscall pc passthrough", pc_o_a, 32'h1000_0010);
        checkOutput("syscall delayslot passthrough", {31'h0, ds_a}, 32'h1);
        nextCycle();
        is_in_delayslot_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("syscall flush", {31'h0, flush_a}, 32'h1);
        checkOutput("syscall new_pc", new_pc_a, 32'h40);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("syscall flush ends", {31'h0, flush_a}, 32'h0);
        nextCycle();
        idleCycles(3);

        // eret with EPC forwarded from WB.
        cp0_epc_i      = 32'h100;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd14;
        wb_cp0_data_i  = 32'h200;
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("eret epc forward", epc_a, 32'h200);
        checkOutput("eret code", exc_a, 32'he);
        nextCycle();
        clearCp0();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("eret new_pc", new_pc_a, 32'h200);
        checkOutput("eret new_pc fc3", new_pc_b, 32'h200);
        nextCycle();
        idleCycles(4);

        // Interrupt held off by bubbles, then taken over a simultaneous syscall.
        cp0_status_i = 32'h0000_0401;
        cp0_cause_i  = 32'h0000_0400;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("int pending bubble 2", {31'h0, pend_a}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("int pending bubble 3", {31'h0, pend_a}, 32'h1);
        nextCycle();
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("int beats syscall", exc_a, 32'h1);
        nextCycle();
        clearCp0();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("int pending cleared", {31'h0, pend_a}, 32'h0);
        nextCycle();
        idleCycles(4);

        // Stall suppresses invalid+ov; code 0xa once the stall drops.
        applyStimulus(1, 1, 0, 0, 1, 0, 1);
        checkOutput("stalled code", exc_a, 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        checkOutput("no flush after stall", {31'h0, flush_a}, 32'h0);
        checkOutput("invalid beats ov", exc_a, 32'ha);
        nextCycle();
        idleCycles(4);

        // Three-cycle flush on trap; syscall during it is ignored.
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        checkOutput("trap code fc3", exc_b, 32'hd);
        nextCycle();
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("syscall in flush fc3", exc_b, 32'h0);
        checkOutput("flush fc3 cycle 1", {31'h0, flush_b}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush fc3 cycle 2", {31'h0, flush_b}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush fc3 cycle 3", {31'h0, flush_b}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush fc3 ends", {31'h0, flush_b}, 32'h0);
        nextCycle();
        idleCycles(2);

        // Reset pulse in the middle of a flush.
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("flush after rst", {31'h0, flush_b}, 32'h0);
        checkOutput("new_pc after rst", new_pc_b, 32'h0);
        checkOutput("syscall after rst", exc_b, 32'h8);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush after rst syscall", {31'h0, flush_b}, 32'h1);
        checkOutput("new_pc after rst syscall", new_pc_b, 32'h40);
        nextCycle();
        idleCycles(4);

        // Cause forwarding only replaces bits 9:8; bit 10 from WB is ignored.
        cp0_status_i   = 32'h0000_0401;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd13;
        wb_cp0_data_i  = 32'h0000_0400;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("cause bit10 not forwarded", exc_a, 32'h0);
        nextCycle();
        cp0_status_i  = 32'h0000_0201;
        wb_cp0_data_i = 32'h0000_0200;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("cause bit9 forwarded", exc_a, 32'h1);
        nextCycle();
        clearCp0();
        idleCycles(4);

        // EXL blocks interrupts; Status forwarded from WB enables them.
        cp0_status_i = 32'h0000_0403;
        cp0_cause_i  = 32'h0000_0400;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("exl masks int", exc_a, 32'h0);
        nextCycle();
        cp0_status_i   = 32'h0;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd12;
        wb_cp0_data_i  = 32'h0000_0401;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("status forwarded int", exc_b, 32'h1);
        nextCycle();
        clearCp0();
        idleCycles(4);

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 120; i++) begin
            logic [31:0] st_pick [5] = '{32'h0, 32'h401, 32'h403, 32'h201, 32'hff01};
            logic [31:0] ca_pick [4] = '{32'h0, 32'h400, 32'h200, 32'h100};
            logic [4:0]  ad_pick [4] = '{5'd12, 5'd13, 5'd14, 5'd3};
            rst                 = ($urandom_range(0, 40) == 0);
            cp0_status_i        = st_pick[$urandom_range(0, 4)];
            cp0_cause_i         = ca_pick[$urandom_range(0, 3)];
            cp0_epc_i           = $urandom;
            wb_cp0_we_i         = ($urandom_range(0, 2) == 0);
            wb_cp0_waddr_i      = ad_pick[$urandom_range(0, 3)];
            wb_cp0_data_i       = $urandom;
            current_inst_addr_i = $urandom;
            is_in_delayslot_i   = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0);
            nextCycle();
        end
        rst = 1'b0;
        clearCp0();
        idleCycles(5);

        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
